// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one RAM port between NREQ cache requesters.
// Latency: grant registered 1 cycle after a request in IDLE; 2-cycle gap between grants.
// Backpressure: the RAM's ramstate gates req_wait; a grant is held until the owner drops
//   its request, or it reaches MAXBEATS completed accesses while someone else waits.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   req_ren/req_wen      per-requester read/write request (index 2c = CPU c I$, 2c+1 = D$)
//   req_addr/req_store   flattened 32-bit address/write data, requester i at [32i+31:32i]
//   req_wait             per-requester wait, low on the cycle that requester's access completes
//   req_load             read data broadcast to all requesters
//   ramREN/ramWEN/ramaddr/ramstore  RAM command side
//   ramload/ramstate     RAM response side (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
//   grant_valid/grant_id current owner of the RAM port
module ram_rr_arbiter #(
  parameter int  NREQ     = 4,
  parameter int  MAXBEATS = 8,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NREQ-1:0]     req_ren,
  input  logic [NREQ-1:0]     req_wen,
  input  logic [NREQ*32-1:0]  req_addr,
  input  logic [NREQ*32-1:0]  req_store,
  output logic [NREQ-1:0]     req_wait,
  output logic [31:0]         req_load,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  logic [1:0]          ramstate,
  output logic                grant_valid,
  output logic [IDW-1:0]      grant_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [IDW-1:0]  grant_id_q;
  logic [IDW-1:0]  sel_d;
  logic [IDW-1:0]  scan_idx;
  logic [7:0]      beat_cnt_q;
  logic [7:0]      beat_cnt_d;
  logic            grant_valid_q;

  logic [NREQ-1:0] req_vec;
  logic [NREQ-1:0] other_mask;
  logic            any_req;
  logic            g_req;
  logic            others_pending;
  logic            ram_access;
  logic            beat_limit;

  assign req_vec    = req_ren | req_wen;
  assign any_req    = |req_vec;
  assign ram_access = (ramstate == RS_ACCESS);
  assign g_req      = req_vec[grant_id_q];

  always_comb begin
    other_mask             = '1;
    other_mask[grant_id_q] = 1'b0;
  end
  assign others_pending = |(req_vec & other_mask);

  // Scan from the farthest offset down to rr_ptr itself so the closest
  // active requester (in rotation order) is the last one written.
  always_comb begin
    sel_d    = rr_ptr_q;
    scan_idx = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_vec[scan_idx]) begin
        sel_d = scan_idx;
      end
    end
  end

  assign rr_ptr_d   = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
  assign beat_cnt_d = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
  // Counts the access completing this cycle, so the limit bites on the
  // MAXBEATS-th completion rather than one later.
  assign beat_limit = ({1'b0, beat_cnt_q} + 9'd1) >= 9'(MAXBEATS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      beat_cnt_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_id_q    <= sel_d;
            beat_cnt_q    <= '0;
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
          end
        end
        GRANT: begin
          if (!g_req) begin
            state_q       <= RELEASE;
            grant_valid_q <= 1'b0;
          end else begin
            if (ram_access) begin
              beat_cnt_q <= beat_cnt_d;
            end
            if (ram_access && beat_limit && others_pending) begin
              state_q       <= RELEASE;
              grant_valid_q <= 1'b0;
            end
          end
        end
        RELEASE: begin
          rr_ptr_q <= rr_ptr_d;
          state_q  <= IDLE;
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The owner's command passes straight through so it can move its address
  // between beats; everything is forced idle outside GRANT.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_load = '0;
    if (grant_valid_q) begin
      ramWEN               = req_wen[grant_id_q];
      ramREN               = req_ren[grant_id_q] & ~req_wen[grant_id_q];
      ramaddr              = req_addr[{grant_id_q, 5'd0} +: 32];
      ramstore             = req_store[{grant_id_q, 5'd0} +: 32];
      req_wait[grant_id_q] = ~ram_access;
      req_load             = ramload;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule
